// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller with read latency and byte/halfword read-modify-write
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, op, addr,      access request from the MEM stage (sampled only in IDLE)
//   wdata
//   busy, done,         status: busy while not IDLE, one-cycle done pulse,
//   misalign            misalign qualifies done for rejected accesses
//   rdata               extended load result, held until the next successful load
//   mem_addr, mem_wdata word-aligned address and full write word to data memory
//   mem_w, mem_r        data memory write / read enables
//   mem_rdata           data memory read word, big-endian byte order
module mem_access_ctrl #(
    parameter int RD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_RMW_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_d, done_d, misalign_d, mem_w_d, mem_r_d;
    logic [31:0] rdata_d, mem_addr_d, mem_wdata_d;

    // Extract and extend the addressed lane of a big-endian word.
    function automatic logic [31:0] load_ext(input logic [2:0] o, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (o)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte (SB) or halfword (SH) of the old word with store data.
    function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] off,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (o == OP_SB) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = d[15:0];
        end else begin
            r[31:16] = d[15:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_q      <= 3'd0;
            off_q     <= 2'd0;
            wdata_q   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_w     <= 1'b0;
            mem_r     <= 1'b0;
            rdata     <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            op_q      <= op_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            misalign  <= misalign_d;
            mem_w     <= mem_w_d;
            mem_r     <= mem_r_d;
            rdata     <= rdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        mem_w_d     = mem_w;
        mem_r_d     = mem_r;
        rdata_d     = rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state)
            S_IDLE: begin
                if (req) begin
                    op_d       = op;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {addr[31:2], 2'b00};
                    if ((((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
                        (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00))) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else if (op == OP_SW) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = wdata;
                        mem_w_d     = 1'b1;
                    end else begin
                        // Sub-word stores need the old word first, so they read like loads.
                        state_d = (op == OP_SB || op == OP_SH) ? S_RMW_READ : S_READ_WAIT;
                        mem_r_d = 1'b1;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_READ_WAIT: begin
                if (cnt == 4'd0) begin
                    rdata_d = load_ext(op_q, off_q, mem_rdata);
                    mem_r_d = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RMW_READ: begin
                if (cnt == 4'd0) begin
                    mem_wdata_d = merge(op_q, off_q, mem_rdata, wdata_q);
                    mem_r_d     = 1'b0;
                    mem_w_d     = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_WRITE: begin
                mem_w_d = 1'b0;
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int RD_LAT = 4;

    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011;
    localparam logic [2:0] LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misalign, mem_w, mem_r;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];

    mem_access_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .misalign(misalign), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_r(mem_r),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_w) mem[mem_addr[7:2]] <= mem_wdata;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          rcyc;
        int          wcyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          rcyc = 0;
    int          wcyc = 0;
    int          overlap = 0;
    int          done_cnt = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
        h = (w >> (8 * (2 - int'(a[1:0])))) & 32'hFFFF;
        case (o)
            LB:      return b[7] ? (b | 32'hFFFFFF00) : b;
            LBU:     return b;
            LH:      return h[15] ? (h | 32'hFFFF0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w, input logic [31:0] d);
        int          sh;
        logic [31:0] m;
        if (o == SW) return d;
        sh = (o == SB) ? 8 * (3 - int'(a[1:0])) : 8 * (2 - int'(a[1:0]));
        m  = ((o == SB) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~m) | ((d << sh) & m);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            rcyc = 0;
            wcyc = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) accept_cyc = cyc;
            if (mem_r) rcyc++;
            if (mem_w) wcyc++;
            if (mem_r && mem_w) overlap++;
            if (done) begin
                exp_t e;
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
                    check("mem_r_cycles", 32'(rcyc), 32'(e.rcyc));
                    check("mem_w_cycles", 32'(wcyc), 32'(e.wcyc));
                end
                rcyc = 0;
                wcyc = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input bit hold);
        exp_t        e;
        logic        mis, is_load;
        logic [31:0] old_word, exp_word;
        int          n;
        mis = (((o == LH) || (o == LHU) || (o == SH)) && a[0]) ||
              (((o == LW) || (o == SW)) && (a[1:0] != 2'b00));
        is_load  = (o <= LW);
        old_word = mem[a[7:2]];
        exp_word = (mis || is_load) ? old_word : st_model(o, a, old_word, d);
        if (!mis && is_load) last_rdata = ld_model(o, a, old_word);
        e.rdata = last_rdata;
        e.mis   = mis;
        e.lat   = mis ? 0 : is_load ? RD_LAT : (o == SW) ? 1 : RD_LAT + 1;
        e.rcyc  = (mis || o == SW) ? 0 : RD_LAT;
        e.wcyc  = (mis || is_load) ? 0 : 1;
        sb_q.push_back(e);

        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(negedge clk);
        if (!hold) req = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("mem_word", mem[a[7:2]], exp_word);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ctl", {28'd0, done, misalign, mem_r, mem_w}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        access(LB,  32'h11, 32'h0, 0);
        access(LBU, 32'h11, 32'h0, 0);
        access(LH,  32'h12, 32'h0, 0);
        access(LHU, 32'h10, 32'h0, 0);
        access(LW,  32'h10, 32'h0, 0);
        access(LB,  32'h13, 32'h0, 0);
        access(SW,  32'h20, 32'h11223344, 0);
        access(SB,  32'h21, 32'h000000EE, 0);
        access(LW,  32'h22, 32'h0, 0);
        access(SH,  32'h13, 32'hCAFE, 0);
        access(SH,  32'h12, 32'h0000BEEF, 0);
        access(LH,  32'h12, 32'h0, 0);

        d0 = done_cnt;
        access(LBU, 32'h13, 32'h0, 1);
        repeat (4) @(negedge clk);
        check("one_access_per_accept", 32'(done_cnt - d0), 32'd1);

        // Abort an SB while it is still reading the old word.
        @(negedge clk);
        req = 1'b1; op = SB; addr = 32'h22; wdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ctl", {28'd0, done, misalign, mem_r, mem_w}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        last_rdata = 32'd0;
        repeat (RD_LAT + 4) @(negedge clk);
        check("abort_word_kept", mem[8], 32'h11EE3344);
        access(LW, 32'h20, 32'h0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("rw_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter RD_LAT, default 4: number of clock cycles mem_r is held before mem_rdata is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  access request from pipeline MEM stage; sampled only in IDLE.
REQ-005 op  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-006 addr  input  32  byte address of access.
REQ-007 wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 misalign  output  1  high with done when the access was rejected as misaligned.
REQ-011 rdata  output  32  extended load result.
REQ-012 mem_addr  output  32  word-aligned address to data memory.
REQ-013 mem_wdata  output  32  full word to data memory.
REQ-014 mem_w  output  1  data memory write enable.
REQ-015 mem_r  output  1  data memory read enable.
REQ-016 mem_rdata  input  32  data memory read word, big-endian (byte at offset 0 in [31:24]).

Function
REQ-017 States IDLE, READ_WAIT, RMW_READ, WRITE, DONE; registered outputs only.
REQ-018 IDLE + req: capture op, addr, wdata; mem_addr = {addr[31:2],2'b00}; next state per REQ-019..REQ-022.
REQ-019 Misaligned (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0): go to DONE with misalign=1; mem_r and mem_w stay 0.
REQ-020 LB/LBU/LH/LHU/LW: go to READ_WAIT, mem_r=1, wait counter loaded RD_LAT-1.
REQ-021 SB/SH: go to RMW_READ, mem_r=1, counter loaded RD_LAT-1.
REQ-022 SW: go to WRITE, mem_wdata = wdata, mem_w=1.
REQ-023 READ_WAIT/RMW_READ: counter decrements each edge; at the edge where counter==0, sample mem_rdata and drop mem_r.
REQ-024 READ_WAIT exit: load rdata, go to DONE; LW latency = done high in cycle after edge RD_LAT following the accept edge.
REQ-025 Byte select big-endian: offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; halfword offset 0 -> [31:16], 2 -> [15:0].
REQ-026 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-027 RMW_READ exit: mem_wdata = sampled word with the selected byte/halfword replaced by wdata[7:0]/[15:0]; go to WRITE with mem_w=1.
REQ-028 WRITE lasts exactly one cycle; mem_addr and mem_wdata stable throughout; mem_r=0; next state DONE, mem_w=0.
REQ-029 DONE lasts one cycle, done=1; then IDLE, done=0, misalign=0.
REQ-030 req while busy=1 (including DONE) is ignored and is not queued.
REQ-031 rdata holds its value until the next successful load; stores and misaligned accesses leave rdata unchanged.
REQ-032 mem_r and mem_w never high in the same cycle.

Reset
REQ-033 rst_n low forces state IDLE; busy, done, misalign, mem_r, mem_w = 0; rdata, mem_addr, mem_wdata = 0.
REQ-034 Reset asserted mid-operation aborts immediately; no write is issued after reset; the first request after rst_n rises is accepted normally.

Verification
REQ-035 RD_LAT=4, memory word at 0x10 = 0x8899AABB; LB addr 0x11 -> done high in cycle after 4th edge following accept, rdata 0xFFFFFF99; LBU same addr -> 0x00000099.
REQ-036 LH addr 0x12 on same word -> rdata 0xFFFFAABB; LHU addr 0x10 -> 0x00008899; LW addr 0x10 -> 0x8899AABB.
REQ-037 SW addr 0x20 wdata 0x11223344 -> mem_w high exactly one cycle, done on next cycle; SB addr 0x21 wdata 0xEE -> memory word 0x11EE3344, mem_r held 4 cycles before mem_w.
REQ-038 LW addr 0x22, then SH addr 0x13 -> each done with misalign=1 one cycle after accept; mem_r/mem_w never asserted; rdata unchanged.
REQ-039 rst_n pulsed low in RMW_READ of an SB -> outputs clear at once, target word unchanged; req held high during busy -> exactly one access per accept.
